// File: rtl/flap_button_debouncer_pkg.sv
// Shared definitions for the flap button debouncer: FSM state encodings,
// default cycle counts and small elaboration-time helpers.
package flap_pkg;

  typedef logic [1:0] state_t;

  localparam state_t RELEASED     = 2'd0;
  localparam state_t PRESS_WAIT   = 2'd1;
  localparam state_t PRESSED      = 2'd2;
  localparam state_t RELEASE_WAIT = 2'd3;

  // 10 ms debounce, 500 ms first repeat, 250 ms repeat period at 50 MHz
  localparam int DEF_DEBOUNCE_CYCLES      = 500000;
  localparam int DEF_REPEAT_DELAY_CYCLES  = 25000000;
  localparam int DEF_REPEAT_PERIOD_CYCLES = 12500000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width for a terminal count of n, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/flap_button_debouncer_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous board inputs. Both flops
// reset to RESET_VALUE so the synchronized level is defined during reset.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic async_nreset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/flap_button_debouncer.sv
// Push-button debouncer producing the change_state_debounced strobe for the
// flap indicator FSM. Define FLAP_BUTTON_AUTOREPEAT_EN to add auto-repeat
// pulses while the button is held.
//
// state        | meaning
// RELEASED     | button stable released
// PRESS_WAIT   | press seen, counting stable pressed samples
// PRESSED      | press accepted (repeat timer runs here when enabled)
// RELEASE_WAIT | release seen, counting stable released samples
import flap_pkg::*;

module flap_button_debouncer #(
  parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int BUTTON_ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
  input  logic clk,
  input  logic async_nreset,
  input  logic button_raw,
  output logic change_state_debounced,
  output logic button_pressed
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 2 || REPEAT_PERIOD_CYCLES < 2) begin : g_bad_cfg
    $error("flap_button_debouncer: cycle parameters must be at least 2");
  end

  localparam logic RELEASED_LEVEL = (BUTTON_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
`ifdef FLAP_BUTTON_AUTOREPEAT_EN
  localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES);
`else
  localparam int CNT_MAX = DEBOUNCE_CYCLES;
`endif
  localparam int CW = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] CNT_SAT = {CW{1'b1}};
  // The sample that enters a WAIT state is the first stable one, so the
  // D-th stable sample arrives while the counter holds D-2.
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic        button_sync;
  logic        pressed_s;
  state_t      state, state_next;
  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  logic        db_done;
  logic        rpt_hit;
  logic        pulse_d, pressed_d;

  sync_2ff #(.RESET_VALUE(RELEASED_LEVEL)) u_sync (
    .clk          (clk),
    .async_nreset (async_nreset),
    .d            (button_raw),
    .q            (button_sync)
  );

  assign pressed_s = (BUTTON_ACTIVE_LOW != 0) ? ~button_sync : button_sync;
  assign cnt_inc   = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
  assign db_done   = (cnt == DB_LAST);

`ifdef FLAP_BUTTON_AUTOREPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD_CYCLES - 1);

  logic [CW-1:0] rcnt, rcnt_next, rcnt_inc;
  logic          rpt_armed, rpt_armed_next;

  assign rcnt_inc = (rcnt == CNT_SAT) ? rcnt : rcnt + CW'(1);
  assign rpt_hit  = (state == PRESSED) && pressed_s &&
                    (rcnt == (rpt_armed ? RP_LAST : RD_LAST));

  // Repeat timer: runs only while held in PRESSED, zero everywhere else
  always_comb begin
    rcnt_next      = '0;
    rpt_armed_next = rpt_armed;
    if (state == PRESSED && pressed_s) begin
      rcnt_next = rpt_hit ? '0 : rcnt_inc;
    end
    if (state == RELEASED || state == PRESS_WAIT) begin
      rpt_armed_next = 1'b0;
    end else if (rpt_hit) begin
      rpt_armed_next = 1'b1;
    end
  end

  // Repeat timer registers
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      rcnt      <= '0;
      rpt_armed <= 1'b0;
    end else begin
      rcnt      <= rcnt_next;
      rpt_armed <= rpt_armed_next;
    end
  end
`else
  assign rpt_hit = 1'b0;
`endif

  // State register and debounce counter
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state <= RELEASED;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and debounce counter update
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    case (state)
      RELEASED: begin
        if (pressed_s) state_next = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!pressed_s)   state_next = RELEASED;
        else if (db_done) state_next = PRESSED;
        else              cnt_next   = cnt_inc;
      end
      PRESSED: begin
        if (!pressed_s) state_next = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (pressed_s)    state_next = PRESSED;
        else if (db_done) state_next = RELEASED;
        else              cnt_next   = cnt_inc;
      end
      default: state_next = RELEASED;
    endcase
  end

  // Output decode: pulse on acceptance or repeat, level while pressed
  always_comb begin
    pulse_d   = ((state == PRESS_WAIT) && (state_next == PRESSED)) || rpt_hit;
    pressed_d = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
  end

  // Registered outputs
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      change_state_debounced <= 1'b0;
      button_pressed         <= 1'b0;
    end else begin
      change_state_debounced <= pulse_d;
      button_pressed         <= pressed_d;
    end
  end

endmodule
